// File: rtl/lenet_frame_sched_if.sv
// Handshake/control bundle between board controls, image core, LeNet accelerator and the frame scheduler.
interface lenet_frame_sched_if;
  logic       mode_en;
  logic       show_en;
  logic       lenet_data_ready;
  logic       lenet_done;
  logic [3:0] lenet_result;
  logic       lenet_doing_signal;
  logic       lenet_showing_signal;
  logic       lenet_start;
  logic       frame_tick;
  logic [3:0] result;
  logic       result_valid;
  logic       busy;
  logic       err_timeout;
  logic       err_nodata;

  modport master (
    output mode_en, show_en, lenet_data_ready, lenet_done, lenet_result,
    input  lenet_doing_signal, lenet_showing_signal, lenet_start, frame_tick,
           result, result_valid, busy, err_timeout, err_nodata
  );

  modport slave (
    input  mode_en, show_en, lenet_data_ready, lenet_done, lenet_result,
    output lenet_doing_signal, lenet_showing_signal, lenet_start, frame_tick,
           result, result_valid, busy, err_timeout, err_nodata
  );
endinterface

// File: rtl/lenet_frame_sched.sv
// Frame-level scheduler for the camera/LeNet path: picks capture frames, starts the CNN, latches results.
// All outputs registered (1-cycle latency); no backpressure, events are single-cycle pulses.
module lenet_frame_sched #(
  parameter int FRAME_LEN      = 307202,
  parameter int SKIP_FRAMES    = 3,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 22
) (
  input logic           clk25,
  input logic           rst_n,
  lenet_frame_sched_if.slave bus
);
  localparam int FCNT_W = $clog2(FRAME_LEN);
  localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  TCNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_FRAMES);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, COMPUTE} state_t;

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic              frame_tick_q, frame_tick_d;
  logic              doing_q, doing_d;
  logic              showing_q, showing_d;
  logic              start_q, start_d;
  logic [3:0]        result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_nodata_q, err_nodata_d;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fcnt_q         <= '0;
      skip_q         <= '0;
      tcnt_q         <= '0;
      frame_tick_q   <= 1'b0;
      doing_q        <= 1'b0;
      showing_q      <= 1'b0;
      start_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_nodata_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      skip_q         <= skip_d;
      tcnt_q         <= tcnt_d;
      frame_tick_q   <= frame_tick_d;
      doing_q        <= doing_d;
      showing_q      <= showing_d;
      start_q        <= start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      err_timeout_q  <= err_timeout_d;
      err_nodata_q   <= err_nodata_d;
    end
  end

  always_comb begin
    fcnt_d         = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
    // Registered tick lines up with fcnt_q == FRAME_LEN-1, matching the core's counter.
    frame_tick_d   = (fcnt_d == FCNT_LAST);
    showing_d      = bus.show_en & bus.mode_en;
    state_d        = state_q;
    skip_d         = skip_q;
    tcnt_d         = tcnt_q;
    doing_d        = doing_q;
    start_d        = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_timeout_d  = err_timeout_q;
    err_nodata_d   = err_nodata_q;

    case (state_q)
      IDLE: begin
        if (frame_tick_q) begin
          if (skip_q != '0) begin
            skip_d = skip_q - 1'b1;
          end else if (bus.mode_en) begin
            doing_d = 1'b1;
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (!bus.mode_en) begin
          doing_d = 1'b0;
          state_d = IDLE;
        end else if (frame_tick_q) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!bus.mode_en) begin
          doing_d = 1'b0;
          state_d = IDLE;
        end else if (bus.lenet_data_ready) begin
          doing_d = 1'b0;
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = COMPUTE;
        end else if (frame_tick_q) begin
          err_nodata_d = 1'b1;
          doing_d      = 1'b0;
          skip_d       = SKIP_LOAD;
          state_d      = IDLE;
        end
      end
      COMPUTE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (bus.lenet_done) begin
          result_d       = bus.lenet_result;
          result_valid_d = 1'b1;
          skip_d         = SKIP_LOAD;
          state_d        = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          err_timeout_d = 1'b1;
          skip_d        = SKIP_LOAD;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.frame_tick           = frame_tick_q;
  assign bus.lenet_doing_signal   = doing_q;
  assign bus.lenet_showing_signal = showing_q;
  assign bus.lenet_start          = start_q;
  assign bus.result               = result_q;
  assign bus.result_valid         = result_valid_q;
  assign bus.busy                 = busy_q;
  assign bus.err_timeout          = err_timeout_q;
  assign bus.err_nodata           = err_nodata_q;
endmodule

// File: tb/tb_lenet_frame_sched.sv
// Directed bench for lenet_frame_sched with FRAME_LEN=20, SKIP_FRAMES=1, TIMEOUT_CYCLES=50.
module tb_lenet_frame_sched;
  logic clk25 = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  lenet_frame_sched_if bus ();

  lenet_frame_sched #(
    .FRAME_LEN(20), .SKIP_FRAMES(1), .TIMEOUT_CYCLES(50), .CNT_W(22)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #20 clk25 = ~clk25;

  // Cycle k = state visible after k rising edges since reset release (fcnt == k % 20).
  task automatic step();
    @(posedge clk25);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic clear_inputs();
    bus.mode_en          = 1'b0;
    bus.show_en          = 1'b0;
    bus.lenet_data_ready = 1'b0;
    bus.lenet_done       = 1'b0;
    bus.lenet_result     = 4'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(posedge clk25);
    #1;
    rst_n = 1'b0;
    @(posedge clk25);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic pulse_ready();
    bus.lenet_data_ready = 1'b1;
    step();
    bus.lenet_data_ready = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] r);
    bus.lenet_done   = 1'b1;
    bus.lenet_result = r;
    step();
    bus.lenet_done   = 1'b0;
    bus.lenet_result = 4'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({bus.lenet_doing_signal, bus.lenet_showing_signal, bus.lenet_start, bus.frame_tick, bus.result, bus.result_valid, bus.busy, bus.err_timeout, bus.err_nodata} !== 13'd0) $display("FAIL reset_outputs got=%b exp=0", {bus.lenet_doing_signal, bus.lenet_showing_signal, bus.lenet_start, bus.frame_tick, bus.result, bus.result_valid, bus.busy, bus.err_timeout, bus.err_nodata}); else passed++;
    @(posedge clk25);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step_to(18);
    checks++; if (bus.frame_tick !== 1'b0) $display("FAIL tick_early got=%b exp=0", bus.frame_tick); else passed++;
  endtask

  task automatic test_basic();
    bus.mode_en = 1'b1;
    step_to(19);
    checks++; if (bus.frame_tick !== 1'b1) $display("FAIL tick_at_19 got=%b exp=1", bus.frame_tick); else passed++;
    checks++; if (bus.lenet_doing_signal !== 1'b0) $display("FAIL doing_before_tick got=%b exp=0", bus.lenet_doing_signal); else passed++;
    step_to(20);
    checks++; if ({bus.lenet_doing_signal, bus.busy, bus.frame_tick} !== 3'b110) $display("FAIL arm_at_20 got=%b exp=110", {bus.lenet_doing_signal, bus.busy, bus.frame_tick}); else passed++;
    step_to(55);
    checks++; if (bus.lenet_doing_signal !== 1'b1) $display("FAIL doing_in_capture got=%b exp=1", bus.lenet_doing_signal); else passed++;
    pulse_ready();
    checks++; if ({bus.lenet_doing_signal, bus.lenet_start} !== 2'b01) $display("FAIL start_at_56 got=%b exp=01", {bus.lenet_doing_signal, bus.lenet_start}); else passed++;
    step();
    checks++; if (bus.lenet_start !== 1'b0) $display("FAIL start_one_cycle got=%b exp=0", bus.lenet_start); else passed++;
    step_to(66);
    checks++; if ({bus.result_valid, bus.busy} !== 2'b01) $display("FAIL computing got=%b exp=01", {bus.result_valid, bus.busy}); else passed++;
    pulse_done(4'd7);
    checks++; if ({bus.result, bus.result_valid, bus.busy} !== 6'b0111_1_0) $display("FAIL result_7 got=%b exp=011110", {bus.result, bus.result_valid, bus.busy}); else passed++;
    step_to(80);
    checks++; if (bus.lenet_doing_signal !== 1'b0) $display("FAIL skip_frame got=%b exp=0", bus.lenet_doing_signal); else passed++;
    step_to(100);
    checks++; if ({bus.lenet_doing_signal, bus.busy} !== 2'b11) $display("FAIL rearm_100 got=%b exp=11", {bus.lenet_doing_signal, bus.busy}); else passed++;
  endtask

  task automatic test_simultaneous();
    step_to(139);
    checks++; if (bus.frame_tick !== 1'b1) $display("FAIL sim_tick got=%b exp=1", bus.frame_tick); else passed++;
    pulse_ready();
    checks++; if ({bus.lenet_start, bus.err_nodata, bus.busy, bus.lenet_doing_signal} !== 4'b1010) $display("FAIL sim_ready_wins got=%b exp=1010", {bus.lenet_start, bus.err_nodata, bus.busy, bus.lenet_doing_signal}); else passed++;
    step_to(145);
    pulse_done(4'd3);
    checks++; if (bus.result !== 4'd3) $display("FAIL sim_result got=%0d exp=3", bus.result); else passed++;
  endtask

  task automatic test_nodata();
    step_to(200);
    checks++; if (bus.lenet_doing_signal !== 1'b1) $display("FAIL nodata_armed got=%b exp=1", bus.lenet_doing_signal); else passed++;
    step_to(219);
    checks++; if (bus.err_nodata !== 1'b0) $display("FAIL nodata_early got=%b exp=0", bus.err_nodata); else passed++;
    step();
    checks++; if ({bus.err_nodata, bus.busy, bus.lenet_doing_signal} !== 3'b100) $display("FAIL nodata_flag got=%b exp=100", {bus.err_nodata, bus.busy, bus.lenet_doing_signal}); else passed++;
  endtask

  task automatic test_timeout();
    step_to(285);
    pulse_ready();
    checks++; if (bus.lenet_start !== 1'b1) $display("FAIL to_start got=%b exp=1", bus.lenet_start); else passed++;
    step_to(335);
    checks++; if ({bus.err_timeout, bus.busy} !== 2'b01) $display("FAIL to_early got=%b exp=01", {bus.err_timeout, bus.busy}); else passed++;
    step();
    checks++; if ({bus.err_timeout, bus.busy, bus.result, bus.result_valid} !== 7'b10_0011_1) $display("FAIL to_flag got=%b exp=1000111", {bus.err_timeout, bus.busy, bus.result, bus.result_valid}); else passed++;
  endtask

  task automatic test_abort_preview();
    do_reset();
    bus.mode_en = 1'b1;
    step_to(25);
    checks++; if (bus.busy !== 1'b1) $display("FAIL abort_in_arm got=%b exp=1", bus.busy); else passed++;
    bus.mode_en = 1'b0;
    step();
    checks++; if ({bus.busy, bus.lenet_doing_signal, bus.err_nodata, bus.err_timeout} !== 4'b0000) $display("FAIL abort_idle got=%b exp=0000", {bus.busy, bus.lenet_doing_signal, bus.err_nodata, bus.err_timeout}); else passed++;
    step_to(41);
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_stays_idle got=%b exp=0", bus.busy); else passed++;
    bus.show_en = 1'b1;
    step();
    checks++; if (bus.lenet_showing_signal !== 1'b0) $display("FAIL show_no_mode got=%b exp=0", bus.lenet_showing_signal); else passed++;
    bus.mode_en = 1'b1;
    step();
    checks++; if (bus.lenet_showing_signal !== 1'b1) $display("FAIL show_with_mode got=%b exp=1", bus.lenet_showing_signal); else passed++;
  endtask

  task automatic test_reset_compute();
    do_reset();
    bus.mode_en = 1'b1;
    step_to(45);
    pulse_ready();
    step_to(50);
    checks++; if ({bus.busy, bus.lenet_start} !== 2'b10) $display("FAIL rc_computing got=%b exp=10", {bus.busy, bus.lenet_start}); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.lenet_doing_signal, bus.lenet_showing_signal, bus.lenet_start, bus.frame_tick, bus.result, bus.result_valid, bus.busy, bus.err_timeout, bus.err_nodata} !== 13'd0) $display("FAIL rc_async_clear got=%b exp=0", {bus.lenet_doing_signal, bus.lenet_showing_signal, bus.lenet_start, bus.frame_tick, bus.result, bus.result_valid, bus.busy, bus.err_timeout, bus.err_nodata}); else passed++;
    bus.mode_en = 1'b0;
    @(posedge clk25);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step_to(2);
    pulse_done(4'd9);
    checks++; if ({bus.result, bus.result_valid, bus.busy} !== 6'd0) $display("FAIL rc_stray_done got=%b exp=000000", {bus.result, bus.result_valid, bus.busy}); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_nodata();
    test_timeout();
    test_abort_preview();
    test_reset_compute();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/lenet_frame_sched.md
Name: lenet_frame_sched

Overview:
- Frame-level controller that sequences the camera-core / LeNet path. It decides which frames are captured into the CNN input buffer, drives the core's `lenet_doing_signal` and `lenet_showing_signal`, starts the CNN once a capture completes, and latches the classification result.
- It keeps its own frame counter, which runs in lock-step with the core's pixel counter (same clock, same reset). Both blocks release from reset together.
- It sits between the board controls (switches), the image core and the LeNet accelerator.

Parameters:
- FRAME_LEN, 307202: cycles per core frame (640*480+2). The frame counter runs 0..FRAME_LEN-1.
- SKIP_FRAMES, 3: idle frames inserted between two consecutive captures.
- TIMEOUT_CYCLES, 2000000: maximum cycles spent waiting for `lenet_done`.
- CNT_W, 22: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk25  in  1  pixel clock (already decided)
- rst_n  in  1  asynchronous, active-low reset (already decided)
- mode_en  in  1  enable periodic classification (level, synchronous to clk25)
- show_en  in  1  request preview of the downscaled window on VGA
- lenet_data_ready  in  1  one-cycle pulse from core: last window pixel has been written to mem2
- lenet_done  in  1  one-cycle pulse from CNN: inference finished
- lenet_result  in  4  CNN class index; valid in the cycle `lenet_done` is high
- lenet_doing_signal  out  1  capture request; the core samples it at its frame boundary
- lenet_showing_signal  out  1  preview request; the core samples it at its frame boundary
- lenet_start  out  1  one-cycle CNN start pulse
- frame_tick  out  1  high in the last cycle of each frame (same cycle as core counter==c_frame)
- result  out  4  last valid class index
- result_valid  out  1  high once at least one result has been latched
- busy  out  1  FSM not in IDLE
- err_timeout  out  1  sticky flag: CNN did not finish in time
- err_nodata  out  1  sticky flag: capture frame ended without `lenet_data_ready`

Behaviour:
- Reset values: every output is 0, `fcnt` = 0, `skip_cnt` = 0, state = IDLE.
- Frame counter:
  - `fcnt` increments every cycle and wraps to 0 after FRAME_LEN-1.
  - `frame_tick` is a registered output, high exactly when `fcnt` == FRAME_LEN-1.
- `lenet_showing_signal`: registered copy of (`show_en` & `mode_en`), one cycle of latency. It is updated every cycle; the core does its own frame-boundary latching.
- FSM states: IDLE, ARM, CAPTURE, COMPUTE.
  - IDLE, on `frame_tick`:
    - if `skip_cnt` != 0, decrement `skip_cnt`;
    - else if `mode_en` = 1, set `lenet_doing_signal` to 1 and go to ARM.
  - ARM, on `frame_tick`: go to CAPTURE. The core latches doing=1 at this same boundary.
  - CAPTURE, on `lenet_data_ready`, in a single cycle:
    - `lenet_doing_signal` <= 0;
    - `lenet_start` <= 1 for one cycle;
    - timeout counter cleared;
    - go to COMPUTE.
  - CAPTURE, on `frame_tick` without `lenet_data_ready`: set `err_nodata`, set doing <= 0, load `skip_cnt` <= SKIP_FRAMES, go to IDLE.
  - CAPTURE, if `lenet_data_ready` and `frame_tick` arrive in the same cycle: `lenet_data_ready` wins.
  - COMPUTE, on `lenet_done`:
    - `result` <= `lenet_result`;
    - `result_valid` <= 1;
    - `skip_cnt` <= SKIP_FRAMES;
    - go to IDLE.
  - COMPUTE timeout: the timeout counter increments every cycle. On reaching TIMEOUT_CYCLES-1 without `lenet_done`: set `err_timeout`, load `skip_cnt` <= SKIP_FRAMES, go to IDLE. If `lenet_done` and timeout occur in the same cycle, `lenet_done` wins.
- `mode_en` deasserted:
  - in ARM or CAPTURE: abort to IDLE on the next cycle, doing <= 0, `skip_cnt` unchanged, no error flagged;
  - in COMPUTE: no effect; the running inference completes and its result is latched.
- `lenet_done` or `lenet_data_ready` pulses arriving in a state that does not expect them are ignored.
- `busy` is a registered output, equal to (state != IDLE).
- Error flags stay set until `rst_n`. `result` holds its value between results.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any CNN run in flight is simply ignored afterwards.

Test Plan:
- Use FRAME_LEN=20, SKIP_FRAMES=1 and TIMEOUT_CYCLES=50 for all scenarios.
- Basic sequence: reset, `mode_en`=1, `lenet_data_ready` pulse at `fcnt`=15 of the capture frame, `lenet_done` with result 7 after 10 cycles.
  - `lenet_doing_signal` rises on the first tick (cycle 20) and falls the cycle after `lenet_data_ready`.
  - `lenet_start` is a single-cycle pulse.
  - `result`=7 and `result_valid`=1.
  - The next ARM happens 2 ticks later.
- Simultaneous events: `lenet_data_ready` coincides with `frame_tick` in CAPTURE → `lenet_start` fires and `err_nodata` stays 0.
- Missing data: no `lenet_data_ready` during the capture frame → `err_nodata`=1 at that tick, FSM back in IDLE, doing=0.
- Timeout: withhold `lenet_done` → `err_timeout`=1 exactly 50 cycles after `lenet_start`, `busy`=0, `result` unchanged.
- Abort and preview: drop `mode_en` in ARM → IDLE next cycle, no error. `show_en`=1 with `mode_en`=0 → `lenet_showing_signal`=0. Then set `mode_en`=1 → `lenet_showing_signal`=1 one cycle later.
- Reset during COMPUTE: assert `rst_n`=0 → all outputs 0 immediately. A subsequent stray `lenet_done` is ignored.
